// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb
//   Reservation station sitting between the issue stage and a single ALU.
//   It holds DEPTH in-flight ops and snoops NUM_CDB result buses to wake
//   pending operands, including a bypass for an op being issued while its
//   producer broadcasts. One eligible op per cycle moves into a registered
//   valid/ready dispatch stage that tolerates ALU backpressure. A flush
//   (branch rollback) empties the station and the dispatch register.
//
// Build option
//   RS_AGE_ORDER_EN  defined   : a DEPTHxDEPTH age matrix is kept and the
//                                oldest eligible entry is dispatched.
//                    undefined : the lowest-index eligible entry is dispatched.
//   Ports and latency are the same in both builds.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   rdy                   global enable; low freezes every register
//   flush                 rollback; clears all entries and dispatch valid
//   issue_*               issue request (valid/ready), op fields, operand
//                         tags (Q), values (V) and ready flags (R)
//   cdb_valid/tag/data    NUM_CDB broadcast ports, port p at slice p
//   disp_valid/disp_ready registered dispatch handshake toward the ALU
//   disp_*                dispatched op fields
//   count, full           number of busy entries, count==DEPTH
module rs_multi_cdb #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [OP_W-1:0]          issue_op,
  input  logic [TAG_W-1:0]         issue_Qj,
  input  logic [TAG_W-1:0]         issue_Qk,
  input  logic [31:0]              issue_Vj,
  input  logic [31:0]              issue_Vk,
  input  logic                     issue_Rj,
  input  logic                     issue_Rk,
  input  logic [31:0]              issue_imm,
  input  logic [TAG_W-1:0]         issue_rdTag,
  input  logic [31:0]              issue_pc,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  output logic                     disp_valid,
  input  logic                     disp_ready,
  output logic [OP_W-1:0]          disp_op,
  output logic [31:0]              disp_Vj,
  output logic [31:0]              disp_Vk,
  output logic [31:0]              disp_imm,
  output logic [TAG_W-1:0]         disp_rdTag,
  output logic [31:0]              disp_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy, rj, rk;
  logic [OP_W-1:0]  e_op    [DEPTH];
  logic [TAG_W-1:0] e_qj    [DEPTH];
  logic [TAG_W-1:0] e_qk    [DEPTH];
  logic [31:0]      e_vj    [DEPTH];
  logic [31:0]      e_vk    [DEPTH];
  logic [31:0]      e_imm   [DEPTH];
  logic [TAG_W-1:0] e_tag   [DEPTH];
  logic [31:0]      e_pc    [DEPTH];

  logic [DEPTH-1:0] hit_j, hit_k;
  logic [31:0]      wdata_j [DEPTH];
  logic [31:0]      wdata_k [DEPTH];
  logic             byp_j, byp_k;
  logic [31:0]      byp_data_j, byp_data_k;

  logic [DEPTH-1:0] eligible;
  logic             free_any;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_accept;
  logic             disp_load;
  logic             dup_tag;

  assign issue_ready  = |(~busy);
  assign full         = (count == CNT_W'(DEPTH));
  assign eligible     = busy & rj & rk;
  assign issue_accept = issue_valid & free_any;
  assign disp_load    = (~disp_valid | disp_ready) & (|eligible);

  // CDB snoop; ports are scanned high to low so the lowest matching port wins.
  always_comb begin
    byp_j      = 1'b0;
    byp_k      = 1'b0;
    byp_data_j = '0;
    byp_data_k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_j[i]   = 1'b0;
      hit_k[i]   = 1'b0;
      wdata_j[i] = '0;
      wdata_k[i] = '0;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == e_qj[i]) begin
          hit_j[i]   = 1'b1;
          wdata_j[i] = cdb_data[p*32 +: 32];
        end
        if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == e_qk[i]) begin
          hit_k[i]   = 1'b1;
          wdata_k[i] = cdb_data[p*32 +: 32];
        end
      end
    end
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == issue_Qj) begin
        byp_j      = 1'b1;
        byp_data_j = cdb_data[p*32 +: 32];
      end
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == issue_Qk) begin
        byp_k      = 1'b1;
        byp_data_k = cdb_data[p*32 +: 32];
      end
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age[j][i] = 1 means entry j is older than entry i.
  logic [DEPTH-1:0] age [DEPTH];
  logic [DEPTH-1:0] older_elig;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_elig[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        older_elig[i] = older_elig[i] | (age[j][i] & eligible[j]);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (eligible[i] && !older_elig[i]) sel_idx = IDX_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else begin
        if (issue_accept) begin
          age[free_idx] <= '0;
          // Every entry still busy after this edge is older than the new one.
          for (int j = 0; j < DEPTH; j++)
            age[j][free_idx] <= busy[j] & ~(disp_load && sel_idx == IDX_W'(j));
        end
        if (disp_load) begin
          age[sel_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) age[j][sel_idx] <= 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (eligible[i]) sel_idx = IDX_W'(i);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      rj         <= '0;
      rk         <= '0;
      count      <= '0;
      disp_valid <= 1'b0;
      disp_op    <= '0;
      disp_Vj    <= '0;
      disp_Vk    <= '0;
      disp_imm   <= '0;
      disp_rdTag <= '0;
      disp_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]  <= '0;
        e_qj[i]  <= '0;
        e_qk[i]  <= '0;
        e_vj[i]  <= '0;
        e_vk[i]  <= '0;
        e_imm[i] <= '0;
        e_tag[i] <= '0;
        e_pc[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy       <= '0;
        count      <= '0;
        disp_valid <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && !rj[i] && hit_j[i]) begin
            rj[i]   <= 1'b1;
            e_vj[i] <= wdata_j[i];
          end
          if (busy[i] && !rk[i] && hit_k[i]) begin
            rk[i]   <= 1'b1;
            e_vk[i] <= wdata_k[i];
          end
        end

        if (disp_load) begin
          busy[sel_idx] <= 1'b0;
          disp_valid    <= 1'b1;
          disp_op       <= e_op[sel_idx];
          disp_Vj       <= e_vj[sel_idx];
          disp_Vk       <= e_vk[sel_idx];
          disp_imm      <= e_imm[sel_idx];
          disp_rdTag    <= e_tag[sel_idx];
          disp_pc       <= e_pc[sel_idx];
        end else if (disp_ready) begin
          disp_valid <= 1'b0;
        end

        // free_idx is never busy, so it cannot collide with the wakeup or
        // the dispatched entry above.
        if (issue_accept) begin
          busy[free_idx]  <= 1'b1;
          e_op[free_idx]  <= issue_op;
          e_qj[free_idx]  <= issue_Qj;
          e_qk[free_idx]  <= issue_Qk;
          e_imm[free_idx] <= issue_imm;
          e_tag[free_idx] <= issue_rdTag;
          e_pc[free_idx]  <= issue_pc;
          rj[free_idx]    <= issue_Rj | byp_j;
          rk[free_idx]    <= issue_Rk | byp_k;
          e_vj[free_idx]  <= (!issue_Rj && byp_j) ? byp_data_j : issue_Vj;
          e_vk[free_idx]  <= (!issue_Rk && byp_k) ? byp_data_k : issue_Vk;
        end

        count <= count + CNT_W'(issue_accept) - CNT_W'(disp_load);
      end
    end
  end

  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = i + 1; j < DEPTH; j++)
        if (busy[i] && busy[j] && e_tag[i] == e_tag[j]) dup_tag = 1'b1;
  end

  a_unique_rdtag: assert property (@(posedge clk) disable iff (!rst_n) !dup_tag);

endmodule

// File: tb/tb_rs_multi_cdb.sv
module tb_rs_multi_cdb;
  localparam int DEPTH   = 16;
  localparam int TAG_W   = 4;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 3;
  localparam int CT_W    = NUM_CDB * TAG_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1, flush = 1'b0, issue_valid = 1'b0, issue_ready;
  logic [OP_W-1:0] issue_op = '0;
  logic [TAG_W-1:0] issue_Qj = '0, issue_Qk = '0, issue_rdTag = '0;
  logic [31:0] issue_Vj = '0, issue_Vk = '0, issue_imm = '0, issue_pc = '0;
  logic issue_Rj = 1'b0, issue_Rk = 1'b0;
  logic [NUM_CDB-1:0] cdb_valid = '0;
  logic [CT_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*32-1:0] cdb_data = '0;
  logic disp_valid, disp_ready = 1'b1;
  logic [OP_W-1:0] disp_op;
  logic [31:0] disp_Vj, disp_Vk, disp_imm, disp_pc;
  logic [TAG_W-1:0] disp_rdTag;
  logic [$clog2(DEPTH):0] count;
  logic full;

  always #5 clk = ~clk;

  rs_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Rj(issue_Rj), .issue_Rk(issue_Rk), .issue_imm(issue_imm),
    .issue_rdTag(issue_rdTag), .issue_pc(issue_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_Vj(disp_Vj), .disp_Vk(disp_Vk), .disp_imm(disp_imm),
    .disp_rdTag(disp_rdTag), .disp_pc(disp_pc), .count(count), .full(full)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: a table of entries plus an issue sequence number for age.
  bit               m_busy [DEPTH];
  bit               m_rj   [DEPTH];
  bit               m_rk   [DEPTH];
  logic [TAG_W-1:0] m_qj   [DEPTH];
  logic [TAG_W-1:0] m_qk   [DEPTH];
  logic [TAG_W-1:0] m_tag  [DEPTH];
  logic [31:0]      m_vj   [DEPTH];
  logic [31:0]      m_vk   [DEPTH];
  logic [31:0]      m_imm  [DEPTH];
  logic [31:0]      m_pc   [DEPTH];
  logic [OP_W-1:0]  m_op   [DEPTH];
  int               m_seq  [DEPTH];
  int               seq_ctr;
  bit               m_dv;
  logic [OP_W-1:0]  m_dop;
  logic [31:0]      m_dvj, m_dvk, m_dimm, m_dpc;
  logic [TAG_W-1:0] m_dtag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] bus_lookup(input logic [TAG_W-1:0] t);
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) return {1'b1, cdb_data[p*32 +: 32]};
    return 33'd0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 1'b0; m_rj[i] = 1'b0; m_rk[i] = 1'b0;
    end
    m_dv = 1'b0;
    seq_ctr = 0;
  endtask

  task automatic model_step();
    int sel, fr;
    bit load;
    logic [32:0] h;
    if (!rdy) return;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      m_dv = 1'b0;
      return;
    end
    sel = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_rj[i] && m_rk[i]) begin
`ifdef RS_AGE_ORDER_EN
        if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    load = (!m_dv || disp_ready) && sel >= 0;
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && fr < 0) fr = i;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i]) begin
        if (!m_rj[i]) begin
          h = bus_lookup(m_qj[i]);
          if (h[32]) begin m_rj[i] = 1'b1; m_vj[i] = h[31:0]; end
        end
        if (!m_rk[i]) begin
          h = bus_lookup(m_qk[i]);
          if (h[32]) begin m_rk[i] = 1'b1; m_vk[i] = h[31:0]; end
        end
      end
    if (load) begin
      m_dv = 1'b1; m_dop = m_op[sel]; m_dvj = m_vj[sel]; m_dvk = m_vk[sel];
      m_dimm = m_imm[sel]; m_dtag = m_tag[sel]; m_dpc = m_pc[sel];
      m_busy[sel] = 1'b0;
    end else if (disp_ready) begin
      m_dv = 1'b0;
    end
    if (issue_valid && fr >= 0) begin
      m_busy[fr] = 1'b1; m_op[fr] = issue_op; m_qj[fr] = issue_Qj; m_qk[fr] = issue_Qk;
      m_imm[fr] = issue_imm; m_tag[fr] = issue_rdTag; m_pc[fr] = issue_pc;
      m_rj[fr] = issue_Rj; m_vj[fr] = issue_Vj; m_rk[fr] = issue_Rk; m_vk[fr] = issue_Vk;
      if (!issue_Rj) begin
        h = bus_lookup(issue_Qj);
        if (h[32]) begin m_rj[fr] = 1'b1; m_vj[fr] = h[31:0]; end
      end
      if (!issue_Rk) begin
        h = bus_lookup(issue_Qk);
        if (h[32]) begin m_rk[fr] = 1'b1; m_vk[fr] = h[31:0]; end
      end
      m_seq[fr] = seq_ctr;
      seq_ctr++;
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(m_count()));
    chk("full", 32'(full), 32'(m_count() == DEPTH));
    chk("issue_ready", 32'(issue_ready), 32'(m_count() < DEPTH));
    chk("disp_valid", 32'(disp_valid), 32'(m_dv));
    if (m_dv) begin
      chk("disp_op", 32'(disp_op), 32'(m_dop));
      chk("disp_Vj", disp_Vj, m_dvj);
      chk("disp_Vk", disp_Vk, m_dvk);
      chk("disp_imm", disp_imm, m_dimm);
      chk("disp_rdTag", 32'(disp_rdTag), 32'(m_dtag));
      chk("disp_pc", disp_pc, m_dpc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0; cdb_valid = '0;
  endtask

  task automatic set_issue(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] qj,
                           input logic rj_in, input logic [31:0] vj,
                           input logic rk_in, input logic [31:0] vk);
    issue_valid = 1'b1; issue_rdTag = tag; issue_Qj = qj; issue_Rj = rj_in; issue_Vj = vj;
    issue_Qk = '0; issue_Rk = rk_in; issue_Vk = vk;
    issue_op = OP_W'(tag) + 6'd1; issue_imm = 32'h1000 + 32'(tag); issue_pc = 32'h4000 + 32'(tag) * 4;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [TAG_W-1:0] free_tags[$];
    bit used;
    rdy         = ($urandom_range(0, 9) != 0);
    flush       = ($urandom_range(0, 59) == 0);
    disp_ready  = ($urandom_range(0, 9) < 7);
    issue_valid = ($urandom_range(0, 2) != 0);
    issue_op    = OP_W'($urandom);
    issue_Qj    = TAG_W'($urandom);
    issue_Qk    = TAG_W'($urandom);
    issue_Rj    = ($urandom_range(0, 1) == 1);
    issue_Rk    = ($urandom_range(0, 1) == 1);
    issue_Vj    = $urandom; issue_Vk = $urandom;
    issue_imm   = $urandom; issue_pc = $urandom;
    for (int t = 0; t < (1 << TAG_W); t++) begin
      used = 1'b0;
      for (int i = 0; i < DEPTH; i++) if (m_busy[i] && m_tag[i] == TAG_W'(t)) used = 1'b1;
      if (!used) free_tags.push_back(TAG_W'(t));
    end
    issue_rdTag = (free_tags.size() > 0) ? free_tags[$urandom_range(0, free_tags.size() - 1)] : '0;
    cdb_valid = NUM_CDB'($urandom);
    cdb_tag   = CT_W'($urandom);
    cdb_data  = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    int xfers, first_zero;
    logic [TAG_W-1:0] first_tag, second_tag;

    // Reset state
    model_reset();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_disp_Vj", disp_Vj, 32'd0);
    rst_n = 1'b1;
    idle();

    // 1: reset mid-stream with 5 busy entries and a held dispatch
    disp_ready = 1'b0;
    set_issue(4'd0, 4'd0, 1'b1, 32'd11, 1'b1, 32'd12); step();
    for (int t = 1; t <= 5; t++) begin
      set_issue(TAG_W'(t), 4'd15, 1'b0, 32'd0, 1'b1, 32'd1); step();
    end
    idle();
    chk("t1_pre_count", 32'(count), 32'd5);
    chk("t1_pre_dv", 32'(disp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_dv", 32'(disp_valid), 32'd0);
    chk("t1_issue_ready", 32'(issue_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // 2: both operands ready, dispatched after the next edge
    disp_ready = 1'b1;
    set_issue(4'd3, 4'd0, 1'b1, 32'd5, 1'b1, 32'd7); step();
    chk("t2_count1", 32'(count), 32'd1);
    chk("t2_dv_early", 32'(disp_valid), 32'd0);
    idle(); step();
    chk("t2_dv", 32'(disp_valid), 32'd1);
    chk("t2_Vj", disp_Vj, 32'd5);
    chk("t2_Vk", disp_Vk, 32'd7);
    chk("t2_tag", 32'(disp_rdTag), 32'd3);
    chk("t2_count0", 32'(count), 32'd0);

    // 3: issue-cycle bypass from CDB port 1
    do_flush();
    set_issue(4'd5, 4'd9, 1'b0, 32'd0, 1'b1, 32'd1);
    cdb_valid = 3'b010; cdb_tag = 12'h090; cdb_data = {32'd0, 32'hAB, 32'd0};
    step();
    idle(); step();
    chk("t3_dv", 32'(disp_valid), 32'd1);
    chk("t3_Vj", disp_Vj, 32'hAB);

    // 4: fill, drop, stall, drain
    do_flush();
    disp_ready = 1'b0;
    for (int t = 0; t < DEPTH; t++) begin
      set_issue(TAG_W'(t), TAG_W'(t), 1'b0, 32'd0, 1'b1, 32'd2); step();
    end
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_issue_ready", 32'(issue_ready), 32'd0);
    set_issue(4'd0, 4'd0, 1'b1, 32'd0, 1'b1, 32'd0); step();
    chk("t4_drop_count", 32'(count), 32'd16);
    idle();
    for (int c = 0; c < 6; c++) begin
      cdb_valid = '0;
      for (int p = 0; p < NUM_CDB; p++)
        if (3 * c + p < DEPTH) begin
          cdb_valid[p] = 1'b1;
          cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(3 * c + p);
          cdb_data[p*32 +: 32] = 32'h100 + 32'(3 * c + p);
        end
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_stall_dv", 32'(disp_valid), 32'd1);
      chk("t4_stall_tag", 32'(disp_rdTag), 32'd0);
      chk("t4_stall_Vj", disp_Vj, 32'h100);
    end
    disp_ready = 1'b1;
    xfers = 0; first_zero = -1;
    for (int k = 0; k < 20; k++) begin
      if (disp_valid) xfers++;
      else if (first_zero < 0) first_zero = k;
      step();
    end
    chk("t4_xfers", 32'(xfers), 32'd16);
    chk("t4_consecutive", 32'(first_zero), 32'd16);
    chk("t4_count_end", 32'(count), 32'd0);

    // 5: age order vs index order
    do_flush();
    disp_ready = 1'b1;
    set_issue(4'd1, 4'd1, 1'b0, 32'd0, 1'b1, 32'd0); step();
    set_issue(4'd2, 4'd2, 1'b0, 32'd0, 1'b1, 32'd0); step();
    idle(); cdb_valid = 3'b001; cdb_tag = 12'h001; cdb_data = {32'd0, 32'd0, 32'h11};
    step();
    idle(); step();
    chk("t5_first_out", 32'(disp_rdTag), 32'd1);
    set_issue(4'd4, 4'd4, 1'b0, 32'd0, 1'b1, 32'd0); step();
    idle(); cdb_valid = 3'b011; cdb_tag = 12'h042; cdb_data = {32'd0, 32'h44, 32'h22};
    step();
    idle();
`ifdef RS_AGE_ORDER_EN
    first_tag = 4'd2; second_tag = 4'd4;
`else
    first_tag = 4'd4; second_tag = 4'd2;
`endif
    step();
    chk("t5_order1", 32'(disp_rdTag), 32'(first_tag));
    step();
    chk("t5_order2", 32'(disp_rdTag), 32'(second_tag));

    // 6: flush with 8 busy, a held dispatch and a simultaneous issue
    do_flush();
    disp_ready = 1'b0;
    set_issue(4'd8, 4'd0, 1'b1, 32'd1, 1'b1, 32'd1); step();
    for (int t = 0; t < 8; t++) begin
      set_issue(TAG_W'(t), 4'd15, 1'b0, 32'd0, 1'b1, 32'd0); step();
    end
    chk("t6_pre_count", 32'(count), 32'd8);
    chk("t6_pre_dv", 32'(disp_valid), 32'd1);
    set_issue(4'd9, 4'd0, 1'b1, 32'd3, 1'b1, 32'd3);
    flush = 1'b1;
    step();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_dv", 32'(disp_valid), 32'd0);
    idle(); disp_ready = 1'b1; step();
    chk("t6_not_captured", 32'(count), 32'd0);
    chk("t6_dv_after", 32'(disp_valid), 32'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rand_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
